// File: rtl/io_gpio_pkg.sv
// ============================================================
// io_gpio_pkg : shared constants for the io_gpio_irq block
// Revision    : 1.0
// ============================================================
`default_nettype none

package io_gpio_pkg;

  localparam int NPIN = 8;

  // Word offsets from IO_BASE
  localparam logic [2:0] GPIO_OFS_IN   = 3'd0;
  localparam logic [2:0] GPIO_OFS_OUT  = 3'd1;
  localparam logic [2:0] GPIO_OFS_OE   = 3'd2;
  localparam logic [2:0] GPIO_OFS_IEN  = 3'd3;
  localparam logic [2:0] GPIO_OFS_STAT = 3'd4;

  // Field positions inside IEN and STAT
  localparam int RISE_LSB = 0;
  localparam int FALL_LSB = 8;

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'd0, v};
  endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_sync_edge.sv
// ============================================================
// gpio_sync_edge : 2-flop pin synchronizer with armed edge detect
// Revision       : 1.0
// ============================================================
`default_nettype none

module gpio_sync_edge
  import io_gpio_pkg::*;
#(
  parameter int WIDTH = NPIN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] s3;
  logic [1:0]       arm_cnt;
  logic             armed;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1      <= '0;
      s2      <= '0;
      s3      <= '0;
      arm_cnt <= 2'd0;
    end else begin
      s1 <= pin_in;
      s2 <= s1;
      s3 <= s2;
      if (arm_cnt != 2'd3) begin
        arm_cnt <= arm_cnt + 2'd1;
      end
    end
  end

  // The flop chain leaves reset at zero; hold off edge reporting until
  // real pin values have propagated through s3.
  assign armed = (arm_cnt == 2'd3);
  assign sync  = s2;
  assign rise  = armed ? (s2 & ~s3) : '0;
  assign fall  = armed ? (~s2 & s3) : '0;

endmodule

`default_nettype wire

// File: rtl/io_gpio_irq.sv
// ============================================================
// io_gpio_irq : 8-pin GPIO with edge-capture interrupt on dma_io bus
// Revision    : 1.0
// ============================================================
`default_nettype none

module io_gpio_irq
  import io_gpio_pkg::*;
#(
  parameter logic [13:0] IO_BASE = 14'h3040,
  parameter int          NPIN    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dma_io_we,
  input  logic [13:0]     dma_io_wadr,
  input  logic [31:0]     dma_io_wdata,
  input  logic [13:0]     dma_io_radr,
  input  logic            dma_io_radr_en,
  input  logic [31:0]     dma_io_rdata_in,
  output logic [31:0]     dma_io_rdata,
  input  logic [NPIN-1:0] gpio_in,
  output logic [NPIN-1:0] gpio_out,
  output logic [NPIN-1:0] gpio_oe,
  output logic            gpio_irq
);

  logic [NPIN-1:0]   pin_sync;
  logic [NPIN-1:0]   pin_rise;
  logic [NPIN-1:0]   pin_fall;

  logic [NPIN-1:0]   out_q;
  logic [NPIN-1:0]   oe_q;
  logic [2*NPIN-1:0] ien_q;
  logic [2*NPIN-1:0] stat_q;
  logic [2*NPIN-1:0] stat_clr;
  logic [2*NPIN-1:0] stat_set;
  logic [2*NPIN-1:0] stat_next;
  logic              irq_q;
  logic [31:0]       rdata_q;
  logic              hit_q;

  logic              wr_hit;
  logic              rd_hit;
  logic [2:0]        wr_ofs;
  logic [2:0]        rd_ofs;
  logic [31:0]       rd_sel;
  logic              unused_wdata;

  gpio_sync_edge #(
    .WIDTH (NPIN)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_in (gpio_in),
    .sync   (pin_sync),
    .rise   (pin_rise),
    .fall   (pin_fall)
  );

  assign wr_ofs = dma_io_wadr[2:0];
  assign rd_ofs = dma_io_radr[2:0];

  // IO_BASE is 8-word aligned, so the upper address bits select the block
  // and the low three bits select the register; offsets 5..7 are holes.
  assign wr_hit = dma_io_we && (dma_io_wadr[13:3] == IO_BASE[13:3]) &&
                  (wr_ofs <= GPIO_OFS_STAT);
  assign rd_hit = dma_io_radr_en && (dma_io_radr[13:3] == IO_BASE[13:3]) &&
                  (rd_ofs <= GPIO_OFS_STAT);

  assign unused_wdata = ^dma_io_wdata[31:2*NPIN];

  always_comb begin
    stat_clr = '0;
    if (wr_hit && (wr_ofs == GPIO_OFS_STAT)) begin
      stat_clr = dma_io_wdata[2*NPIN-1:0];
    end
  end

  always_comb begin
    stat_set = '0;
    stat_set[RISE_LSB +: NPIN] = pin_rise;
    stat_set[FALL_LSB +: NPIN] = pin_fall;
  end

  // A new edge outranks a simultaneous write-1-to-clear of the same bit.
  assign stat_next = (stat_q & ~stat_clr) | stat_set;

  always_comb begin
    rd_sel = '0;
    case (rd_ofs)
      GPIO_OFS_IN:   rd_sel[NPIN-1:0] = pin_sync;
      GPIO_OFS_OUT:  rd_sel[NPIN-1:0] = out_q;
      GPIO_OFS_OE:   rd_sel[NPIN-1:0] = oe_q;
      GPIO_OFS_IEN:  rd_sel = zext16(ien_q);
      GPIO_OFS_STAT: rd_sel = zext16(stat_q);
      default:       rd_sel = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q   <= '0;
      oe_q    <= '0;
      ien_q   <= '0;
      stat_q  <= '0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      if (wr_hit) begin
        case (wr_ofs)
          GPIO_OFS_OUT: out_q <= dma_io_wdata[NPIN-1:0];
          GPIO_OFS_OE:  oe_q  <= dma_io_wdata[NPIN-1:0];
          GPIO_OFS_IEN: ien_q <= dma_io_wdata[2*NPIN-1:0];
          default:      ;
        endcase
      end
      stat_q <= stat_next;
      irq_q  <= |(stat_q & ien_q);
      hit_q  <= rd_hit;
      if (rd_hit) begin
        rdata_q <= rd_sel;
      end
    end
  end

  assign dma_io_rdata = hit_q ? rdata_q : dma_io_rdata_in;
  assign gpio_out     = out_q;
  assign gpio_oe      = oe_q;
  assign gpio_irq     = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_io_gpio_irq.sv
// ============================================================
// tb_io_gpio_irq : scoreboard bench for io_gpio_irq
// Revision       : 1.0
// ============================================================
`default_nettype none

module tb_io_gpio_irq;

  localparam logic [13:0] BASE = 14'h3040;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [13:0] wadr;
  logic [31:0] wdata;
  logic [13:0] radr;
  logic        radr_en;
  logic [31:0] rdata_in;
  logic [31:0] rdata;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_oe;
  logic        gpio_irq;

  int n_cmp = 0;
  int n_bad = 0;

  io_gpio_irq #(
    .IO_BASE (BASE),
    .NPIN    (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .dma_io_we       (we),
    .dma_io_wadr     (wadr),
    .dma_io_wdata    (wdata),
    .dma_io_radr     (radr),
    .dma_io_radr_en  (radr_en),
    .dma_io_rdata_in (rdata_in),
    .dma_io_rdata    (rdata),
    .gpio_in         (gpio_in),
    .gpio_out        (gpio_out),
    .gpio_oe         (gpio_oe),
    .gpio_irq        (gpio_irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  m_out, m_oe;
  logic [15:0] m_ien, m_stat;
  logic        m_irq, m_hit;
  logic [7:0]  pin_hist[$];
  logic [31:0] exp_q[$];
  bit          started = 0;

  function automatic bit in_map(input logic [13:0] a);
    return (a >= BASE) && (a <= BASE + 14'd4);
  endfunction

  // Pins appear in IN two clocks after being sampled; an edge is the
  // difference between two consecutive IN values, ignored until three
  // clocks have elapsed since reset.
  always @(posedge clk) begin : model
    logic [7:0]  in_now, rise, fall;
    logic [15:0] clr;
    logic [31:0] v;
    int          ofs;
    if (!rst_n) begin
      m_out = 0; m_oe = 0; m_ien = 0; m_stat = 0; m_irq = 0; m_hit = 0;
      pin_hist.delete();
    end else begin
      in_now = (pin_hist.size() >= 2) ? pin_hist[1] : 8'h00;
      rise = 0; fall = 0;
      if (pin_hist.size() >= 3) begin
        rise = pin_hist[1] & ~pin_hist[2];
        fall = ~pin_hist[1] & pin_hist[2];
      end
      m_hit = radr_en && in_map(radr);
      if (m_hit) begin
        ofs = int'(radr - BASE);
        case (ofs)
          0: v = {24'd0, in_now};
          1: v = {24'd0, m_out};
          2: v = {24'd0, m_oe};
          3: v = {16'd0, m_ien};
          default: v = {16'd0, m_stat};
        endcase
        exp_q.push_back(v);
      end
      m_irq = |(m_stat & m_ien);
      clr = 0;
      if (we && in_map(wadr)) begin
        ofs = int'(wadr - BASE);
        case (ofs)
          1: m_out = wdata[7:0];
          2: m_oe  = wdata[7:0];
          3: m_ien = wdata[15:0];
          4: clr   = wdata[15:0];
          default: ;
        endcase
      end
      m_stat = (m_stat & ~clr) | {fall, rise};
      pin_hist.push_front(gpio_in);
      if (pin_hist.size() > 4) void'(pin_hist.pop_back());
    end
    started = 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (started) begin
      check("gpio_out", {24'd0, gpio_out}, {24'd0, m_out});
      check("gpio_oe",  {24'd0, gpio_oe},  {24'd0, m_oe});
      check("gpio_irq", {31'd0, gpio_irq}, {31'd0, m_irq});
      if (m_hit) begin
        if (exp_q.size() == 0) begin
          check("rd_queue", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("rdata_hit", rdata, e);
        end
      end else begin
        check("rdata_pass", rdata, rdata_in);
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #2;
    we = 0; radr_en = 0; rdata_in = $urandom;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    cyc(); we = 1; wadr = a; wdata = d;
  endtask

  task automatic rd(input logic [13:0] a);
    cyc(); radr_en = 1; radr = a;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    rst_n = 0; we = 0; radr_en = 0; wadr = 0; wdata = 0; radr = 0;
    rdata_in = 32'h0; gpio_in = 8'hFF;
    idle(4);
    rst_n = 1;
    idle(8);                          // pins high through reset: no edges
    wr(BASE + 14'd1, 32'hFFFF_FFA5);
    wr(BASE + 14'd2, 32'h0000_000F);
    rd(BASE + 14'd1);
    rd(BASE + 14'd2);
    rd(BASE + 14'd4);
    idle(2);
    // rise on pin 0 with its rise interrupt enabled
    gpio_in = 8'hFE; idle(5);
    wr(BASE + 14'd4, 32'h0000_FFFF);
    wr(BASE + 14'd3, 32'h0000_0001);
    gpio_in = 8'hFF;
    idle(2); rd(BASE + 14'd4); rd(BASE + 14'd0); idle(2);
    wr(BASE + 14'd4, 32'h0000_0001);
    idle(3);
    // fall on pin 3 with interrupts disabled, then enable it
    wr(BASE + 14'd3, 32'h0);
    gpio_in = 8'hF7; idle(5); rd(BASE + 14'd4);
    wr(BASE + 14'd3, 32'h0000_0800);
    idle(3);
    wr(BASE + 14'd4, 32'h0000_FFFF);
    // rise event and W1C of the same bit on the same edge
    gpio_in = 8'hF6; idle(5);
    wr(BASE + 14'd4, 32'h0000_FFFF);
    gpio_in = 8'hF7;
    cyc();
    wr(BASE + 14'd4, 32'h0000_0001);
    rd(BASE + 14'd4); idle(2);
    // addresses outside the register map
    cyc(); rdata_in = 32'hDEAD_BEEF; radr_en = 1; radr = 14'h0100;
    rd(BASE + 14'd5);
    wr(BASE + 14'd6, 32'hFFFF_FFFF);
    wr(14'h0100, 32'hFFFF_FFFF);
    wr(BASE + 14'd9, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) rd(BASE + 14'(i));
    idle(2);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cyc();
      rst_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 2) == 0) gpio_in ^= 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        we = 1; wdata = $urandom;
        wadr = ($urandom_range(0, 7) == 0) ? 14'($urandom) : BASE + 14'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 2) == 0) begin
        radr_en = 1;
        radr = ($urandom_range(0, 7) == 0) ? 14'($urandom) : BASE + 14'($urandom_range(0, 7));
      end
    end
    rst_n = 1;
    idle(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
